alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle control sequencer for the accumulator ALU. It owns the program counter, instruction register and shift-carry flag. It fetches 9-bit machine codes from instruction memory, presents them to the ALU, and turns the ALU's control outputs into registered write enables for the accumulator, register file and data memory. Relative branches resolve through a 16-entry signed offset table; the block reports completion to the top-level test harness.

## Interface
- PC_W, 10, program counter width; PC wraps modulo 2^PC_W
- HALT_CODE, 9'h000, reserved machine code that terminates the program
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  level; begins execution from PC 0 when idle or done
- instr  input  9  instruction memory read data for address pc (combinational memory)
- relj  input  1  ALU branch-taken flag
- sc_o  input  1  ALU shift-carry out
- mem_write, mem_read, reg_write  input  1 each  ALU control outputs (MemWrite, Memread, RegWrite)
- pc  output  PC_W  instruction memory address
- ir  output  9  registered machine code to the ALU mach_code port
- alu_src  output  1  ir[8], immediate-select to the ALU ALUSrc port
- sc_i  output  1  registered shift-carry to the ALU
- acc_en  output  1  accumulator load strobe
- rf_we, dm_we, dm_re  output  1 each  register file write, data memory write, data memory read
- busy  output  1  high in FETCH, EXEC, MEM
- done  output  1  high in DONE
- cycle_cnt  output  16  executed-cycle count (see Configuration)

## Operation
- States: IDLE, FETCH, EXEC, MEM, DONE.
- IDLE: when start=1, go to FETCH with pc=0 and sc=0.
- FETCH: ir <= instr, then go to EXEC. If instr==HALT_CODE, go to DONE instead; pc and ir hold.
- EXEC: the ALU evaluates ir combinationally.
  - alu_src=1: acc_en=1, pc+1, back to FETCH.
  - op = ir[7:4]:
    - 0, 3, E, F: acc_en=1.
    - 1, 2, 4, 5: acc_en=1 and sc <= sc_o.
    - 6: dm_we=mem_write.
    - 7: dm_re=1, go to MEM.
    - 8: rf_we=reg_write.
    - 9–D: branch.
- Branch: if relj, pc <= pc + sign_extend(lut[ir[3:0]]), else pc+1.
- Non-branch ops: pc <= pc+1. Arithmetic is modulo 2^PC_W in both cases.
- MEM: dm_re=1 and acc_en=1, capturing the synchronous-read mem_data; pc+1; back to FETCH.
- DONE: hold pc and ir; done=1. start=1 restarts at pc 0 (same as IDLE).
- start is ignored while busy.
- Strobes (acc_en, rf_we, dm_we, dm_re) are combinational from state and ir, and never assert outside EXEC or MEM.

## Timing
- Reset values: state=IDLE, pc=0, ir=0, sc_i=0, cycle_cnt=0. All strobes, busy and done are 0.
- Instruction latency:
  - ALU, immediate, store, mov, branch: 2 cycles (FETCH+EXEC).
  - lw: 3 cycles (FETCH+EXEC+MEM).
- Halt: 1 cycle from FETCH to DONE.
- The branch target is visible on pc the cycle after EXEC.
- A taken branch with offset 0 re-executes the same instruction (legal; it loops).
- PC wrap: pc=2^PC_W-1 with a non-branch op goes to 0.
- A backward offset past 0 wraps to the top of the address space.
- If rst_n asserts mid-instruction, state returns to IDLE immediately. No strobe may remain high after reset assertion, even within the same cycle.
- If start is held high through DONE, the program restarts on the next cycle.

## Configuration
- SEQ_CYCLE_COUNT_EN defined:
  - cycle_cnt increments every cycle busy=1, saturating at 16'hFFFF.
  - It clears on the IDLE/DONE-to-FETCH transition and holds in DONE.
- Undefined: cycle_cnt is tied to 0 and no counter register exists.

## Structure
- Shared package alu_pkg holds:
  - typedef enum seq_state_t {IDLE, FETCH, EXEC, MEM, DONE};
  - 4-bit opcode localparams OP_AND..OP_SBL, matching the ALU encoding;
  - HALT_CODE default.
- Sub-module jump_lut: combinational, 4-bit index in, 8-bit signed offset out, contents as a case statement.

## Test plan
- Reset then start with program {9'h105, 9'h000}: one EXEC with alu_src=1 and acc_en=1. Then done=1 at cycle 3; pc holds 1.
- add with sc_o=1 (op 1): sc_i=1 from the next cycle. A following xor leaves sc_i at 1.
- lw at pc 4: dm_re high in both EXEC and MEM, acc_en only in MEM, pc=5 three cycles after FETCH.
- beq at pc 8 with lut[3]=-4 and relj=1: pc=4 next. With relj=0: pc=9.
- pc=1023 executing and with PC_W=10: pc=0. Reset asserted during MEM: all strobes 0 immediately and state IDLE.
- SEQ_CYCLE_COUNT_EN defined, 3-instruction non-load program followed by halt: cycle_cnt=7 in DONE. Undefined: cycle_cnt=0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the accumulator ALU and its control sequencer:
//   - seq_state_t : sequencer FSM state encoding
//   - OP_*        : 4-bit opcode field (mach_code[7:4]) as decoded by the ALU
//   - HALT_CODE_DFLT : reserved machine code that ends a program
//   - helper predicates grouping opcodes by what the sequencer must do
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_XOR = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRL = 4'h5;
    localparam logic [3:0] OP_SW  = 4'h6;
    localparam logic [3:0] OP_LW  = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_BEQ = 4'h9;
    localparam logic [3:0] OP_BNE = 4'hA;
    localparam logic [3:0] OP_BLT = 4'hB;
    localparam logic [3:0] OP_BGT = 4'hC;
    localparam logic [3:0] OP_BRA = 4'hD;
    localparam logic [3:0] OP_OR  = 4'hE;
    localparam logic [3:0] OP_SBL = 4'hF;

    localparam logic [8:0] HALT_CODE_DFLT = 9'h000;

    // Ops whose result goes to the accumulator without touching the carry.
    function automatic logic op_is_acc_only(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_XOR) || (op == OP_OR) || (op == OP_SBL);
    endfunction

    // Ops that load the accumulator and also produce a new shift-carry.
    function automatic logic op_updates_sc(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLL) || (op == OP_SRL);
    endfunction

    // Relative branches resolved through the offset table.
    function automatic logic op_is_branch(input logic [3:0] op);
        return (op >= OP_BEQ) && (op <= OP_BRA);
    endfunction

endpackage

// File: rtl/alu_sequencer_jump_lut.sv
// -----------------------------------------------------------------------------
// jump_lut
// Combinational table of signed relative branch offsets, indexed by the low
// nibble of a branch machine code.
//   idx    in   4  table index (mach_code[3:0])
//   offset out  8  signed two's-complement pc offset
// -----------------------------------------------------------------------------
module jump_lut (
    input  logic        [3:0] idx,
    output logic signed [7:0] offset
);

    always_comb begin
        offset = 8'sd0;
        case (idx)
            4'h0: offset =  8'sd0;     // taken branch to itself: spin loop
            4'h1: offset =  8'sd1;
            4'h2: offset =  8'sd2;
            4'h3: offset = -8'sd4;
            4'h4: offset =  8'sd4;
            4'h5: offset = -8'sd1;
            4'h6: offset =  8'sd8;
            4'h7: offset = -8'sd8;
            4'h8: offset =  8'sd16;
            4'h9: offset = -8'sd16;
            4'hA: offset =  8'sd3;
            4'hB: offset = -8'sd3;
            4'hC: offset =  8'sd32;
            4'hD: offset = -8'sd32;
            4'hE: offset =  8'sd127;
            4'hF: offset = -8'sd128;
            default: offset = 8'sd0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle control sequencer for the accumulator ALU. Owns the program
// counter, instruction register and shift-carry flag; turns the ALU's control
// outputs into write/read strobes for the accumulator, register file and data
// memory.
//
// Optional feature: define SEQ_CYCLE_COUNT_EN to build a saturating 16-bit
// counter of busy cycles on cycle_cnt; otherwise cycle_cnt is tied to 0.
//
// Ports
//   clk         in   1     system clock, rising edge
//   rst_n       in   1     asynchronous reset, active low
//   start       in   1     level; starts a program at pc 0 from IDLE/DONE
//   instr       in   9     instruction memory data at address pc
//   relj        in   1     ALU branch-taken flag
//   sc_o        in   1     ALU shift-carry out
//   mem_write   in   1     ALU MemWrite
//   mem_read    in   1     ALU Memread (loads are decoded here from the opcode)
//   reg_write   in   1     ALU RegWrite
//   pc          out  PC_W  instruction memory address
//   ir          out  9     registered machine code to the ALU
//   alu_src     out  1     ir[8], immediate select
//   sc_i        out  1     registered shift-carry to the ALU
//   acc_en      out  1     accumulator load strobe
//   rf_we       out  1     register file write strobe
//   dm_we       out  1     data memory write strobe
//   dm_re       out  1     data memory read strobe
//   busy        out  1     FETCH, EXEC or MEM
//   done        out  1     DONE
//   cycle_cnt   out  16    busy-cycle count
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start
// FETCH | latch instr into ir, or stop on the halt code
// EXEC  | ALU evaluates ir; strobes, carry update, pc advance or branch
// MEM   | second cycle of a load: synchronous read data into accumulator
// DONE  | program halted, pc/ir frozen, waiting for start to rerun
// -----------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int         PC_W      = 10,
    parameter logic [8:0] HALT_CODE = HALT_CODE_DFLT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [8:0]      instr,
    input  logic            relj,
    input  logic            sc_o,
    input  logic            mem_write,
    input  logic            mem_read,
    input  logic            reg_write,
    output logic [PC_W-1:0] pc,
    output logic [8:0]      ir,
    output logic            alu_src,
    output logic            sc_i,
    output logic            acc_en,
    output logic            rf_we,
    output logic            dm_we,
    output logic            dm_re,
    output logic            busy,
    output logic            done,
    output logic [15:0]     cycle_cnt
);

    seq_state_t      state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [8:0]      ir_nxt;
    logic            sc_q, sc_nxt;
    logic            acc_en_c, rf_we_c, dm_we_c, dm_re_c;

    logic [3:0]        op;
    logic signed [7:0] lut_off;
    logic [PC_W-1:0]   off_ext;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_br;

    // Loads are recognised from the opcode itself, so Memread is redundant.
    logic unused_mem_read;
    assign unused_mem_read = mem_read;

    assign op = ir[7:4];

    jump_lut u_jump_lut (
        .idx    (ir[3:0]),
        .offset (lut_off)
    );

    // Signed cast sign-extends the table entry; sums wrap modulo 2^PC_W.
    assign off_ext = PC_W'(lut_off);
    assign pc_inc  = pc + PC_W'(1);
    assign pc_br   = pc + off_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
            sc_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            sc_q  <= sc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        sc_nxt    = sc_q;
        acc_en_c  = 1'b0;
        rf_we_c   = 1'b0;
        dm_we_c   = 1'b0;
        dm_re_c   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = FETCH;
                    pc_nxt    = '0;
                    sc_nxt    = 1'b0;
                end
            end

            FETCH: begin
                // The halt code is never latched: ir keeps the last real op.
                if (instr == HALT_CODE) begin
                    state_nxt = DONE;
                end else begin
                    ir_nxt    = instr;
                    state_nxt = EXEC;
                end
            end

            EXEC: begin
                state_nxt = FETCH;
                pc_nxt    = pc_inc;
                if (ir[8]) begin
                    acc_en_c = 1'b1;
                end else if (op_is_acc_only(op)) begin
                    acc_en_c = 1'b1;
                end else if (op_updates_sc(op)) begin
                    acc_en_c = 1'b1;
                    sc_nxt   = sc_o;
                end else if (op == OP_SW) begin
                    dm_we_c = mem_write;
                end else if (op == OP_LW) begin
                    // Address goes out now; data lands in the accumulator in MEM.
                    dm_re_c   = 1'b1;
                    state_nxt = MEM;
                    pc_nxt    = pc;
                end else if (op == OP_MOV) begin
                    rf_we_c = reg_write;
                end else if (op_is_branch(op)) begin
                    if (relj) begin
                        pc_nxt = pc_br;
                    end
                end
            end

            MEM: begin
                dm_re_c   = 1'b1;
                acc_en_c  = 1'b1;
                pc_nxt    = pc_inc;
                state_nxt = FETCH;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset also gates the strobes directly so they drop in the same instant
    // rst_n falls, without relying on the state register's clear-to-output path.
    assign acc_en  = acc_en_c & rst_n;
    assign rf_we   = rf_we_c  & rst_n;
    assign dm_we   = dm_we_c  & rst_n;
    assign dm_re   = dm_re_c  & rst_n;

    assign alu_src = ir[8];
    assign sc_i    = sc_q;
    assign busy    = (state == FETCH) || (state == EXEC) || (state == MEM);
    assign done    = (state == DONE);

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cnt_q;
    logic        cnt_clr;

    assign cnt_clr = ((state == IDLE) || (state == DONE)) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (busy && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer. The instruction memory is a combinational
// array indexed by pc; ALU control inputs are driven directly. Inputs change
// and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int PC_W = 10;

`ifdef SEQ_CYCLE_COUNT_EN
    localparam logic [15:0] CNT_HALT1 = 16'd3;
    localparam logic [15:0] CNT_PROG3 = 16'd7;
`else
    localparam logic [15:0] CNT_HALT1 = 16'd0;
    localparam logic [15:0] CNT_PROG3 = 16'd0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [8:0]      instr;
    logic            relj, sc_o, mem_write, mem_read, reg_write;
    logic [PC_W-1:0] pc;
    logic [8:0]      ir;
    logic            alu_src, sc_i, acc_en, rf_we, dm_we, dm_re, busy, done;
    logic [15:0]     cycle_cnt;

    logic [8:0] prog [0:(1<<PC_W)-1];

    int n_vec = 0;
    int n_err = 0;

    assign instr = prog[pc];

    always #5 clk = ~clk;

    alu_sequencer #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .instr     (instr),
        .relj      (relj),
        .sc_o      (sc_o),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .reg_write (reg_write),
        .pc        (pc),
        .ir        (ir),
        .alu_src   (alu_src),
        .sc_i      (sc_i),
        .acc_en    (acc_en),
        .rf_we     (rf_we),
        .dm_we     (dm_we),
        .dm_re     (dm_re),
        .busy      (busy),
        .done      (done),
        .cycle_cnt (cycle_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < (1 << PC_W); i++) prog[i] = 9'h000;
    endtask

    task automatic start_prog();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (done) return;
            @(negedge clk);
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; relj = 1'b0; sc_o = 1'b0;
        mem_write = 1'b0; mem_read = 1'b0; reg_write = 1'b0;
        clear_prog();

        // reset state
        #1;
        chk("rst_pc",    pc, 0);
        chk("rst_ir",    ir, 0);
        chk("rst_sc",    sc_i, 0);
        chk("rst_strb",  {acc_en, rf_we, dm_we, dm_re}, 0);
        chk("rst_flags", {busy, done}, 0);
        chk("rst_cnt",   cycle_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        chk("idle_stay", {busy, done}, 0);

        // immediate then halt
        prog[0] = 9'h105;
        start_prog();
        chk("t1_fetch_busy", busy, 1);
        chk("t1_fetch_acc",  acc_en, 0);
        step(1);
        chk("t1_exec_ir",    ir, 9'h105);
        chk("t1_exec_src",   alu_src, 1);
        chk("t1_exec_acc",   acc_en, 1);
        step(1);
        chk("t1_pc1",        pc, 1);
        chk("t1_fetch2_acc", acc_en, 0);
        step(1);
        chk("t1_done",       {busy, done}, 2'b01);
        chk("t1_pc_hold",    pc, 1);
        chk("t1_ir_hold",    ir, 9'h105);
        chk("t1_cnt",        cycle_cnt, CNT_HALT1);

        // add (carry out 1), xor, store, halt
        clear_prog();
        prog[0] = 9'h010; prog[1] = 9'h030; prog[2] = 9'h060;
        sc_o = 1'b1; mem_write = 1'b1;
        start_prog();
        step(1);
        chk("t2_add_acc",  acc_en, 1);
        chk("t2_add_sc0",  sc_i, 0);
        step(1);
        chk("t2_sc_set",   sc_i, 1);
        sc_o = 1'b0;
        step(1);
        chk("t2_xor_acc",  acc_en, 1);
        step(1);
        chk("t2_xor_sc",   sc_i, 1);
        chk("t2_pc2",      pc, 2);
        step(1);
        chk("t2_sw_we",    dm_we, 1);
        chk("t2_sw_acc",   acc_en, 0);
        step(2);
        chk("t2_done",     done, 1);
        chk("t2_cnt",      cycle_cnt, CNT_PROG3);

        // start held through DONE restarts next cycle with carry cleared
        start = 1'b1;
        step(1);
        chk("t2_restart",  {busy, pc}, {1'b1, 10'd0});
        chk("t2_sc_clr",   sc_i, 0);
        step(1);
        chk("t2_busy_ign", {busy, ir}, {1'b1, 9'h010});
        start = 1'b0;
        mem_write = 1'b0;
        wait_done(40);

        // lw at pc 4
        clear_prog();
        for (int i = 0; i < 4; i++) prog[i] = 9'h101;
        prog[4] = 9'h070;
        start_prog();
        step(8);
        chk("t3_pc4",      pc, 4);
        step(1);
        chk("t3_exec_re",  dm_re, 1);
        chk("t3_exec_acc", acc_en, 0);
        step(1);
        chk("t3_mem_re",   dm_re, 1);
        chk("t3_mem_acc",  acc_en, 1);
        chk("t3_mem_pc",   pc, 4);
        step(1);
        chk("t3_pc5",      pc, 5);
        chk("t3_re_off",   dm_re, 0);
        wait_done(10);

        // mov then beq at pc 8 (lut[3] = -4), taken
        clear_prog();
        prog[0] = 9'h080;
        for (int i = 1; i < 8; i++) prog[i] = 9'h101;
        prog[8] = 9'h093;
        relj = 1'b1; reg_write = 1'b1;
        start_prog();
        step(1);
        chk("t4_mov_we",   rf_we, 1);
        chk("t4_mov_acc",  acc_en, 0);
        step(15);
        chk("t4_pc8",      pc, 8);
        prog[4] = 9'h000;
        step(1);
        chk("t4_br_strb",  {acc_en, rf_we, dm_we, dm_re}, 0);
        step(1);
        chk("t4_taken",    pc, 4);
        wait_done(10);

        // same branch, not taken
        prog[4] = 9'h101; prog[9] = 9'h000;
        relj = 1'b0; reg_write = 1'b0;
        start_prog();
        step(1);
        chk("t4_mov_we0",  rf_we, 0);
        step(17);
        chk("t4_not_tkn",  pc, 9);
        wait_done(10);

        // backward wrap past 0, forward wrap at top, reset during MEM
        clear_prog();
        prog[0] = 9'h099;
        for (int i = 1008; i < 1024; i++) prog[i] = 9'h101;
        relj = 1'b1;
        start_prog();
        step(2);
        chk("t5_back_wrap", pc, 1008);
        step(30);
        chk("t5_pc_top",    pc, 1023);
        prog[0] = 9'h070;
        step(2);
        chk("t5_top_wrap",  pc, 0);
        step(2);
        chk("t5_mem_strb",  {acc_en, dm_re, busy}, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_strb",  {acc_en, rf_we, dm_we, dm_re}, 0);
        chk("t5_rst_state", {busy, done}, 0);
        chk("t5_rst_pc",    pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        chk("t5_idle",      {busy, done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
